// File: rtl/interrupt_request_controller.sv
// interrupt_request_controller
// Front end of the interrupt path: synchronises and edge-detects the external
// request lines, latches pending events, applies the INT1 mask, and turns the
// PC_LD_INT0/PC_LD_INT1 acknowledges into pending clears and a CAUSE index.
// Optional feature macro: IRQ_SYNC_EN
//   defined   -> 2-flop synchronisers on every request line (3 CLK latency)
//   undefined -> inputs feed the previous-value flops directly (1 CLK latency),
//                only for request lines that are already synchronous to CLK.
module interrupt_request_controller #(
   parameter int              N1         = 4,
   parameter int              CW         = 2,
   parameter logic [N1-1:0]   LEVEL_MASK = '0
) (
   input  logic          CLK,
   input  logic          RESET_N,
   input  logic          COMMIT,
   input  logic          IRQ0_IN,
   input  logic [N1-1:0] IRQ1_IN,
   input  logic          MASK_WR,
   input  logic [N1-1:0] MASK_DIN,
   input  logic          ACK0,
   input  logic          ACK1,
   output logic          INT0,
   output logic          INT1,
   output logic [CW-1:0] CAUSE,
   output logic [N1-1:0] PENDING,
   output logic [N1-1:0] MASK_OUT
);

   // Request levels after the (optional) synchroniser stage.
   logic          irq0_sync;
   logic [N1-1:0] irq1_sync;

   // Previous-value flops used by the rising-edge detectors.
   logic          irq0_prev;
   logic [N1-1:0] irq1_prev;

   // One-cycle event strobes from the edge detectors.
   logic          irq0_edge;
   logic [N1-1:0] irq1_edge;

   // Pending state, mask and the cause register.
   logic          pend0;
   logic [N1-1:0] pend1;
   logic [N1-1:0] pend1_next;
   logic [N1-1:0] mask;
   logic [CW-1:0] cause;

   // Priority resolution over the unmasked pending sources.
   logic [N1-1:0] active;
   logic          any_active;
   logic [CW-1:0] winner;

   // Acknowledges only take effect on a committed instruction.
   logic          ack0_fire;
   logic          ack1_fire;

`ifdef IRQ_SYNC_EN
   logic          irq0_meta;
   logic [N1-1:0] irq1_meta;

   // Two-flop synchronisers; reset high so a line held high through reset
   // never looks like a fresh rising edge.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         irq0_meta <= 1'b1;
         irq0_sync <= 1'b1;
         irq1_meta <= '1;
         irq1_sync <= '1;
      end else begin
         irq0_meta <= IRQ0_IN;
         irq0_sync <= irq0_meta;
         irq1_meta <= IRQ1_IN;
         irq1_sync <= irq1_meta;
      end
   end
`else
   assign irq0_sync = IRQ0_IN;
   assign irq1_sync = IRQ1_IN;
`endif

   // Previous-value flops, also reset high to suppress a spurious edge.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         irq0_prev <= 1'b1;
         irq1_prev <= '1;
      end else begin
         irq0_prev <= irq0_sync;
         irq1_prev <= irq1_sync;
      end
   end

   assign irq0_edge  = irq0_sync & ~irq0_prev;
   assign irq1_edge  = irq1_sync & ~irq1_prev;

   assign ack0_fire  = ACK0 & COMMIT;
   assign ack1_fire  = ACK1 & COMMIT;

   assign active     = pend1 & ~mask;
   assign any_active = |active;

   // Lowest-index unmasked pending source wins; scanning downwards lets the
   // lowest index overwrite any higher one.
   always_comb begin
      winner = '0;
      for (int i = N1 - 1; i >= 0; i--) begin
         if (active[i]) begin
            winner = CW'(i);
         end
      end
   end

   // Next pending state: level sources track the line, edge sources set on an
   // edge and clear on an acknowledge of that source, with set taking priority
   // so an event arriving during its own acknowledge is kept.
   always_comb begin
      pend1_next = pend1;
      for (int i = 0; i < N1; i++) begin
         if (LEVEL_MASK[i]) begin
            pend1_next[i] = irq1_sync[i];
         end else if (irq1_edge[i]) begin
            pend1_next[i] = 1'b1;
         end else if (ack1_fire && any_active && (winner == CW'(i))) begin
            pend1_next[i] = 1'b0;
         end
      end
   end

   // Non-maskable pending bit; a new edge beats a simultaneous acknowledge.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         pend0 <= 1'b0;
      end else if (irq0_edge) begin
         pend0 <= 1'b1;
      end else if (ack0_fire) begin
         pend0 <= 1'b0;
      end
   end

   // Maskable pending bits.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         pend1 <= '0;
      end else begin
         pend1 <= pend1_next;
      end
   end

   // Mask register; everything masked out of reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         mask <= '1;
      end else if (MASK_WR) begin
         mask <= MASK_DIN;
      end
   end

   // CAUSE captures the serviced source; an acknowledge with nothing
   // unmasked-pending leaves it untouched.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         cause <= '0;
      end else if (ack1_fire && any_active) begin
         cause <= winner;
      end
   end

   assign INT0     = pend0;
   assign INT1     = any_active;
   assign CAUSE    = cause;
   assign PENDING  = pend1;
   assign MASK_OUT = mask;

endmodule
